// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: in-order instruction bus request/response channel
interface if_fetch_queue_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: in-order fetch queue between the PC register and IF/ID with jump flush
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [DW-1:0] NOP = DW'(32'h00000013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [2:0]            hold_flag_i,
  input  logic [AW-1:0]         pc_i,
  output logic                  pc_stall_o,
  if_fetch_queue_if.master      bus,
  output logic                  inst_valid_o,
  output logic [DW-1:0]         inst_o,
  output logic [AW-1:0]         inst_addr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0]    addr [DEPTH];
  logic [DW-1:0]    data [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    wr_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]    used, pend, discard_cnt;
  logic             reserve, fill, drop, deq;
  assign bus.req_valid = !rst && !jump_flag_i &&
                         ({1'b0, used} + {1'b0, discard_cnt} < (CW+1)'(DEPTH));
  assign bus.req_addr = pc_i;
  // Handshake decode and head-of-queue presentation toward IF/ID
  always_comb begin
    pc_stall_o   = !(bus.req_valid && bus.req_ready);
    reserve      = !pc_stall_o;
    inst_valid_o = !rst && used != '0 && filled[rd_ptr];
    inst_o       = inst_valid_o ? data[rd_ptr] : NOP;
    inst_addr_o  = inst_valid_o ? addr[rd_ptr] : '0;
    drop         = bus.rsp_valid && discard_cnt != '0;
    fill         = bus.rsp_valid && discard_cnt == '0 && pend != '0;
    deq          = inst_valid_o && hold_flag_i < 3'b010;
  end
  // Slot bookkeeping; pend counts reserved slots still waiting for their response
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      pend        <= '0;
      discard_cnt <= '0;
      filled      <= '0;
    end else if (jump_flag_i) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      pend        <= '0;
      filled      <= '0;
      discard_cnt <= discard_cnt + pend -
                     CW'(bus.rsp_valid && (discard_cnt != '0 || pend != '0));
    end else begin
      if (reserve) begin
        addr[wr_ptr] <= pc_i;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (fill) begin
        data[fill_ptr] <= bus.rsp_data;
        fill_ptr       <= fill_ptr + 1'b1;
      end
      if (drop) discard_cnt <= discard_cnt - 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      filled <= (filled & ~(DEPTH'(deq) << rd_ptr) & ~(DEPTH'(reserve) << wr_ptr))
                | (DEPTH'(fill) << fill_ptr);
      used   <= used + CW'(reserve) - CW'(deq);
      pend   <= pend + CW'(reserve) - CW'(fill);
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized and directed checks against a queue-based reference model
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 1'b0;
  logic        rst, jump;
  logic [2:0]  hold;
  logic [31:0] pc;
  logic        pc_stall, inst_valid;
  logic [31:0] inst, inst_addr;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  int          disc = 0, bus_out = 0;
  if_fetch_queue_if #(.AW(32), .DW(32)) bus ();
  if_fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump), .hold_flag_i(hold), .pc_i(pc),
    .pc_stall_o(pc_stall), .bus(bus), .inst_valid_o(inst_valid),
    .inst_o(inst), .inst_addr_o(inst_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit j, input logic [2:0] h, input logic [31:0] p,
                      input bit rdy, input bit rsp_en);
    bit rv, ev, rsp;
    logic [31:0] rd;
    int pnd;
    @(negedge clk);
    rsp = rsp_en && bus_out > 0;
    rd  = $urandom;
    rst = r; jump = j; hold = h; pc = p;
    bus.req_ready = rdy; bus.rsp_valid = rsp; bus.rsp_data = rd;
    #1;
    rv = !r && !j && (m_addr.size() + disc < DEPTH);
    ev = !r && m_data.size() > 0;
    chk("req_valid", 32'(bus.req_valid), 32'(rv));
    chk("pc_stall", 32'(pc_stall), 32'(!(rv && rdy)));
    chk("req_addr", bus.req_addr, p);
    chk("inst_valid", 32'(inst_valid), 32'(ev));
    if (ev) begin
      chk("inst", inst, m_data[0]);
      chk("inst_addr", inst_addr, m_addr[0]);
    end else begin
      chk("inst_nop", inst, NOP);
      chk("inst_addr_zero", inst_addr, 32'h0);
    end
    @(posedge clk);
    if (r) begin
      m_addr.delete(); m_data.delete(); disc = 0; bus_out = 0;
    end else begin
      pnd = m_addr.size() - m_data.size();
      if (rv && rdy) bus_out++;
      if (rsp) bus_out--;
      if (j) begin
        disc = disc + pnd - ((rsp && disc + pnd > 0) ? 1 : 0);
        m_addr.delete(); m_data.delete();
      end else begin
        if (ev && h < 3'b010) begin
          void'(m_addr.pop_front());
          void'(m_data.pop_front());
        end
        if (rsp) begin
          if (disc > 0) disc--;
          else if (pnd > 0) m_data.push_back(rd);
        end
        if (rv && rdy) m_addr.push_back(p);
      end
    end
  endtask
  initial begin
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
    rst = 1'b1; jump = 1'b0; hold = '0; pc = '0;
    repeat (2) step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'(i * 4), 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 3'b010, 32'h40 + 32'(i * 4), 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h80, 0, 1);
    step(0, 0, 3'b010, 32'h200, 1, 0);
    step(0, 0, 3'b010, 32'h204, 1, 0);
    step(0, 1, 0, 32'h208, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h100 + 32'(i * 4), i == 0, 1);
    step(0, 0, 0, 32'h300, 1, 0);
    step(0, 1, 0, 32'h304, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h400, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b011, 32'h500 + 32'(i * 4), 1, 0);
    step(0, 1, 3'b011, 32'h600, 1, 0);
    step(0, 0, 3'b011, 32'h604, 1, 0);
    step(1, 0, 0, 32'h608, 1, 1);
    step(0, 0, 0, 32'h700, 1, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom % 150 == 0, $urandom % 12 == 0,
           ($urandom % 4 == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, $urandom % 4 != 0, 1'($urandom % 2));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
